// File: rtl/sort_array_reader_pkg.sv
// rtl/sort_array_reader_pkg.sv - shared sort datapath defaults and FSM state encoding
//   WIDTH_DEF/DEPTH_DEF/ADDR_W_DEF : default bank geometry
//   ST_*_ENC                       : 3-bit state codes shared with the sort controller
//   state_t                        : enum built on those codes
package sort_pkg;

    localparam int WIDTH_DEF  = 16;
    localparam int DEPTH_DEF  = 8;
    localparam int ADDR_W_DEF = 3;

    localparam logic [2:0] ST_IDLE_ENC    = 3'd0;
    localparam logic [2:0] ST_REQ_ENC     = 3'd1;
    localparam logic [2:0] ST_WAIT_ENC    = 3'd2;
    localparam logic [2:0] ST_PRESENT_ENC = 3'd3;
    localparam logic [2:0] ST_DONE_ENC    = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE_ENC,
        S_REQ     = ST_REQ_ENC,
        S_WAIT    = ST_WAIT_ENC,
        S_PRESENT = ST_PRESENT_ENC,
        S_DONE    = ST_DONE_ENC
    } state_t;

endpackage

// File: rtl/sort_array_reader_if.sv
// rtl/sort_array_reader_if.sv - bank read port plus output word stream
//   rd_en/rd_addr/rd_data : registered bank read (data valid the cycle after rd_en)
//   out_data/out_valid/out_ready/out_last : valid/ready word stream to the consumer
//   master : reader side, slave : bank + consumer side
interface sort_array_reader_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  rd_data;
    logic [WIDTH-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output rd_en, rd_addr, out_data, out_valid, out_last,
        input  rd_data, out_ready
    );

    modport slave (
        input  rd_en, rd_addr, out_data, out_valid, out_last,
        output rd_data, out_ready
    );
endinterface

// File: rtl/sort_array_reader_hold_reg.sv
// rtl/sort_array_reader_hold_reg.sv - WIDTH-bit load-enabled holding register
//   clk    : rising-edge clock
//   rst    : asynchronous clear, active-low
//   load_i : capture d_i on this edge
//   d_i    : data in
//   q_o    : held data
module hold_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= '0;
        end else if (load_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;
endmodule

// File: rtl/sort_array_reader.sv
// rtl/sort_array_reader.sv - walks the sorted bank 0..DEPTH-1 and streams each word out
//   clk   : rising-edge clock
//   rst   : asynchronous reset, active-low
//   start : one-cycle request to begin read-out, honoured only when idle
//   bus   : master side of bank read port and output stream
//   busy  : high from accepted start through the done cycle
//   done  : one-cycle pulse after the last word is accepted
module sort_array_reader
    import sort_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    sort_array_reader_if.master  bus,
    output logic                 busy,
    output logic                 done
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic              load_data;
    logic              is_last;

    assign is_last = (index_q == LAST_IDX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        load_data = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_REQ;
                    index_d = '0;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // bank data for the request issued last cycle is present now
                load_data = 1'b1;
                state_d   = S_PRESENT;
            end
            S_PRESENT: begin
                if (bus.out_ready) begin
                    if (is_last) begin
                        state_d = S_DONE;
                    end else begin
                        index_d = index_q + ADDR_W'(1);
                        state_d = S_REQ;
                    end
                end
            end
            S_DONE: begin
                // park the address at 0 so rd_addr reads 0 while idle
                index_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                index_d = '0;
            end
        endcase
    end

    hold_reg #(.WIDTH(WIDTH)) u_hold (
        .clk    (clk),
        .rst    (rst),
        .load_i (load_data),
        .d_i    (bus.rd_data),
        .q_o    (bus.out_data)
    );

    assign bus.rd_en     = (state_q == S_REQ);
    assign bus.rd_addr   = index_q;
    assign bus.out_valid = (state_q == S_PRESENT);
    assign bus.out_last  = (state_q == S_PRESENT) && is_last;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
endmodule

// File: tb/tb_sort_array_reader.sv
// tb/tb_sort_array_reader.sv - bench for sort_array_reader at DEPTH 8, 1 and 5
module tb_sort_array_reader;

    typedef struct {
        logic [15:0] data;
        logic        last;
        int          off;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start8 = 1'b0, start1 = 1'b0, start5 = 1'b0;
    logic busy8, done8, busy1, done1, busy5, done5;

    always #5 clk = ~clk;

    sort_array_reader_if #(.WIDTH(16), .ADDR_W(3)) b8 ();
    sort_array_reader_if #(.WIDTH(16), .ADDR_W(1)) b1 ();
    sort_array_reader_if #(.WIDTH(16), .ADDR_W(3)) b5 ();

    sort_array_reader #(.WIDTH(16), .DEPTH(8), .ADDR_W(3)) u8 (
        .clk(clk), .rst(rst), .start(start8), .bus(b8), .busy(busy8), .done(done8));
    sort_array_reader #(.WIDTH(16), .DEPTH(1), .ADDR_W(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .bus(b1), .busy(busy1), .done(done1));
    sort_array_reader #(.WIDTH(16), .DEPTH(5), .ADDR_W(3)) u5 (
        .clk(clk), .rst(rst), .start(start5), .bus(b5), .busy(busy5), .done(done5));

    logic [15:0] bank8 [0:7] = '{16'd5, 16'd8, 16'd12, 16'd20, 16'd33, 16'd47, 16'd60, 16'd99};
    logic [15:0] bank5 [0:4] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055};

    // registered bank read ports
    always @(posedge clk) begin
        if (b8.rd_en) b8.rd_data <= bank8[b8.rd_addr];
        if (b1.rd_en) b1.rd_data <= 16'hFFFF;
        if (b5.rd_en) b5.rd_data <= (b5.rd_addr < 3'd5) ? bank5[b5.rd_addr] : 16'hDEAD;
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // DEPTH=8 monitor, sampled on the falling edge
    beat_t got8[$];
    int    rd_addrs8[$];
    int    c0 = 0;
    int    done8_cnt = 0, done8_off = -1, rd8_cnt = 0, rd8_while_valid = 0, stab_viol = 0;
    logic  pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [15:0] pd = '0;

    always @(negedge clk) begin
        beat_t b;
        if (!rst) begin
            pv = 1'b0;
        end else begin
            if (pv && !pr) begin
                if (!(b8.out_valid && b8.out_data == pd && b8.out_last == pl)) stab_viol++;
            end
            if (b8.out_valid && b8.out_ready) begin
                b.data = b8.out_data;
                b.last = b8.out_last;
                b.off  = cyc - c0;
                got8.push_back(b);
            end
            if (b8.rd_en) begin
                rd8_cnt++;
                rd_addrs8.push_back(int'(b8.rd_addr));
                if (b8.out_valid) rd8_while_valid++;
            end
            if (done8) begin
                done8_cnt++;
                done8_off = cyc - c0;
            end
            pv = b8.out_valid;
            pr = b8.out_ready;
            pd = b8.out_data;
            pl = b8.out_last;
        end
    end

    task automatic clr8();
        got8.delete();
        rd_addrs8.delete();
        done8_cnt = 0;
        done8_off = -1;
        rd8_cnt = 0;
        rd8_while_valid = 0;
        stab_viol = 0;
    endtask

    // one DEPTH=8 read-out; optional stall on a given beat, optional stray starts
    task automatic run8(input int stall_beat, input int stall_len, input bit poke);
        int st;
        st = 0;
        clr8();
        start8 = 1'b1;
        c0 = cyc;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done8_cnt > 0) break;
            if (b8.out_valid && got8.size() == stall_beat && st < stall_len) begin
                b8.out_ready = 1'b0;
                st++;
            end else begin
                b8.out_ready = 1'b1;
            end
            start8 = poke && ((b8.out_valid && (got8.size() == 1 || got8.size() == 5)) || done8);
            tick();
        end
        start8 = 1'b0;
        b8.out_ready = 1'b1;
    endtask

    beat_t exp8[8];

    task automatic cmp8(input string name, input int shift_from, input int shift);
        int n;
        check({name, "_beats"}, got8.size(), 8);
        n = (got8.size() < 8) ? got8.size() : 8;
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_b%0d_data", name, k), got8[k].data, exp8[k].data);
            check($sformatf("%s_b%0d_last", name, k), got8[k].last, exp8[k].last);
            check($sformatf("%s_b%0d_cyc", name, k), got8[k].off,
                  exp8[k].off + ((k >= shift_from) ? shift : 0));
        end
        check({name, "_done_cnt"}, done8_cnt, 1);
        check({name, "_rd_cnt"}, rd8_cnt, 8);
        check({name, "_rd_in_present"}, rd8_while_valid, 0);
        check({name, "_stable"}, stab_viol, 0);
        if (rd_addrs8.size() > 0) check({name, "_first_addr"}, rd_addrs8[0], 0);
    endtask

    initial begin
        int d_off, b_cnt, l_cnt, l_pos, max_addr, i;
        logic [15:0] bd;
        logic        bl;
        int          boff;

        exp8[0] = '{16'd5,  1'b0, 3};
        exp8[1] = '{16'd8,  1'b0, 6};
        exp8[2] = '{16'd12, 1'b0, 9};
        exp8[3] = '{16'd20, 1'b0, 12};
        exp8[4] = '{16'd33, 1'b0, 15};
        exp8[5] = '{16'd47, 1'b0, 18};
        exp8[6] = '{16'd60, 1'b0, 21};
        exp8[7] = '{16'd99, 1'b1, 24};

        b8.out_ready = 1'b0;
        b1.out_ready = 1'b0;
        b5.out_ready = 1'b0;
        #2 rst = 1'b0;
        tick();
        tick();
        check("rst_rd_en", b8.rd_en, 0);
        check("rst_rd_addr", b8.rd_addr, 0);
        check("rst_out_data", b8.out_data, 0);
        check("rst_out_valid", b8.out_valid, 0);
        check("rst_out_last", b8.out_last, 0);
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        rst = 1'b1;
        b8.out_ready = 1'b1;
        b1.out_ready = 1'b1;
        b5.out_ready = 1'b1;
        tick();
        check("idle_busy", busy8, 0);

        // basic stream
        run8(99, 0, 1'b0);
        cmp8("basic", 99, 0);
        check("basic_done_cyc", done8_off, 25);
        check("basic_total_cyc", cyc - c0, 26);
        check("basic_idle_after", busy8, 0);
        check("basic_addr_idle", b8.rd_addr, 0);

        // backpressure on word 2 (value 12) for 4 cycles
        run8(2, 4, 1'b0);
        cmp8("bp", 2, 4);
        check("bp_done_cyc", done8_off, 29);

        // stray starts at words 1 and 5 and in the done cycle
        run8(99, 0, 1'b1);
        cmp8("ign", 99, 0);
        check("ign_done_cyc", done8_off, 25);
        check("ign_idle_after_done_start", busy8, 0);
        run8(99, 0, 1'b0);
        cmp8("restart", 99, 0);

        // reset while a word is presented
        b8.out_ready = 1'b0;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (i = 0; i < 20 && !b8.out_valid; i++) tick();
        check("mid_valid_reached", b8.out_valid, 1);
        clr8();
        rst = 1'b0;
        #1;
        check("mid_rst_valid", b8.out_valid, 0);
        check("mid_rst_data", b8.out_data, 0);
        check("mid_rst_last", b8.out_last, 0);
        check("mid_rst_rd_en", b8.rd_en, 0);
        check("mid_rst_busy", busy8, 0);
        check("mid_rst_done", done8, 0);
        tick();
        tick();
        rst = 1'b1;
        b8.out_ready = 1'b1;
        for (i = 0; i < 4; i++) tick();
        check("post_rst_busy", busy8, 0);
        check("post_rst_valid", b8.out_valid, 0);
        check("post_rst_rd_cnt", rd8_cnt, 0);
        check("post_rst_done_cnt", done8_cnt, 0);

        // DEPTH=1
        b_cnt = 0; d_off = -1; bd = '0; bl = 1'b0; boff = -1;
        start1 = 1'b1;
        c0 = cyc;
        tick();
        start1 = 1'b0;
        for (i = 0; i < 30; i++) begin
            if (b1.out_valid && b1.out_ready) begin
                b_cnt++; bd = b1.out_data; bl = b1.out_last; boff = cyc - c0;
            end
            if (done1) begin
                d_off = cyc - c0;
                break;
            end
            tick();
        end
        check("d1_beats", b_cnt, 1);
        check("d1_data", bd, 16'hFFFF);
        check("d1_last", bl, 1);
        check("d1_beat_cyc", boff, 3);
        check("d1_done_cyc", d_off, 4);

        // DEPTH=5
        b_cnt = 0; l_cnt = 0; l_pos = -1; max_addr = 0; d_off = -1;
        start5 = 1'b1;
        c0 = cyc;
        tick();
        start5 = 1'b0;
        for (i = 0; i < 60; i++) begin
            if (int'(b5.rd_addr) > max_addr) max_addr = int'(b5.rd_addr);
            if (b5.out_valid && b5.out_ready) begin
                check($sformatf("d5_b%0d_data", b_cnt), b5.out_data, 16'h0011 * (b_cnt + 1));
                if (b5.out_last) begin
                    l_cnt++;
                    l_pos = b_cnt;
                end
                b_cnt++;
            end
            if (done5) begin
                d_off = cyc - c0;
                break;
            end
            tick();
        end
        check("d5_beats", b_cnt, 5);
        check("d5_last_cnt", l_cnt, 1);
        check("d5_last_pos", l_pos, 4);
        check("d5_max_addr", max_addr, 4);
        check("d5_done_cyc", d_off, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
